reg_file_2r1w: RTL and testbench
================================

// Module: reg_file_2r1w
// PURPOSE
//  Parametrised register file: two read ports, one write port with byte enables.
//  Reads are registered (1-cycle latency). A built-in clear engine fills every
//  entry with CLR_VALUE after reset and on request, one entry per cycle.
//  Storage for datapath blocks (FIFOs, small register banks) needing dual read.
// PARAMETERS
//  ADDR_WIDTH  3      address bits; DEPTH = 2**ADDR_WIDTH entries
//  DATA_WIDTH  8      word width; must be a multiple of 8; NB = DATA_WIDTH/8
//  CLR_VALUE   '0     DATA_WIDTH-bit value written by the clear engine
// PORTS
//  clk        in   1           single clock, all logic on rising edge
//  reset_n    in   1           synchronous, active-low reset
//  w_en       in   1           write request
//  w_addr     in   ADDR_WIDTH  write address
//  w_data     in   DATA_WIDTH  write data
//  w_be       in   NB          byte enables; bit i covers w_data[8i+7:8i]
//  r_addr_a   in   ADDR_WIDTH  read port A address
//  r_addr_b   in   ADDR_WIDTH  read port B address
//  r_data_a   out  DATA_WIDTH  port A data, registered
//  r_data_b   out  DATA_WIDTH  port B data, registered
//  clr        in   1           request full clear (level or pulse)
//  busy       out  1           clear engine active; writes are dropped
//  w_drop     out  1           1-cycle pulse: a write was dropped last cycle
// BEHAVIOUR
//  Reset (reset_n=0 at an edge): r_data_a=r_data_b=0, w_drop=0, busy=1,
//   state=CLEAR, clr_ptr=0. Array contents are not reset directly.
//  FSM states: CLEAR, IDLE.
//   CLEAR: each cycle mem[clr_ptr]<=CLR_VALUE, clr_ptr++. When clr_ptr==DEPTH-1:
//    write it, go to IDLE, busy=0 next cycle. Takes exactly DEPTH cycles.
//    clr is ignored in CLEAR (no restart).
//   IDLE: clr=1 -> next state CLEAR, clr_ptr=0, busy=1 from next cycle.
//    A write in the same cycle as clr is performed, then overwritten by clear.
//  Reset asserted mid-clear: restarts clear from entry 0.
//  Write (IDLE, w_en=1): for each i with w_be[i]=1, mem[w_addr] byte i <=
//   w_data byte i; other bytes unchanged. w_be=0 -> no change, no w_drop.
//  Write while busy=1 with w_en=1: discarded; w_drop=1 on the next cycle.
//  Read: r_data_x <= mem[r_addr_x] at every edge (latency 1). Ports A and B
//   are independent; same address on both returns identical data.
//  Reads while busy=1: r_data_x <= CLR_VALUE, regardless of address.
//  Read and write to the same address in the same cycle: see CONFIGURATION.
//  Address wrap: none needed; all addresses are in range by width.
// CONFIGURATION
//  RF_WR_BYPASS_EN defined: same-cycle read of the address being written
//   returns the merged new word (enabled bytes from w_data, others from mem)
//   on the next cycle (write-first). Dropped writes are never bypassed.
//  RF_WR_BYPASS_EN undefined: a same-cycle read returns the old word
//   (read-first). The new word is visible from the following read.
// TESTING
//  1 Release reset, hold clr=0 -> busy=1 for DEPTH(8) cycles then 0; read all
//    addresses -> every r_data = CLR_VALUE.
//  2 IDLE, write addr 5 = 8'hA5, be=1; next cycle read A=5, B=5 -> both 8'hA5
//    one cycle after the address is applied.
//  3 DATA_WIDTH=32: write 32'h11223344 to addr 2, then be=4'b0101 data
//    32'hAABBCCDD -> read = 32'h11BB33DD.
//  4 Pulse clr, write addr 1 on each busy cycle -> w_drop=1 one cycle after
//    each; after busy falls, addr 1 reads CLR_VALUE.
//  5 Write addr 3 = 8'h5A while reading addr 3 (old 8'h00) -> r_data_a=8'h5A
//    with RF_WR_BYPASS_EN, 8'h00 without; next read 8'h5A in both.
//  6 Assert reset_n=0 at clr_ptr=4 mid-clear -> busy stays 1, clear restarts,
//    completes DEPTH cycles after release.

Source files
------------

// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: parametrised register file with two registered read ports,
// one byte-enabled write port and a built-in clear engine that fills every
// entry with CLR_VALUE after reset and on request, one entry per cycle.
//
// Optional feature: define RF_WR_BYPASS_EN for write-first behaviour on a
// same-cycle read/write to the same address. When the macro is undefined the
// array is read-first and the new word appears on the following read.
module reg_file_2r1w #(
  parameter int                    ADDR_WIDTH = 3,
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] CLR_VALUE  = '0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    w_en,
  input  logic [ADDR_WIDTH-1:0]   w_addr,
  input  logic [DATA_WIDTH-1:0]   w_data,
  input  logic [DATA_WIDTH/8-1:0] w_be,
  input  logic [ADDR_WIDTH-1:0]   r_addr_a,
  input  logic [ADDR_WIDTH-1:0]   r_addr_b,
  output logic [DATA_WIDTH-1:0]   r_data_a,
  output logic [DATA_WIDTH-1:0]   r_data_b,
  input  logic                    clr,
  output logic                    busy,
  output logic                    w_drop
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH / 8;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   clr_ptr;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    write_ok;
  logic [DATA_WIDTH-1:0]   wr_word;
  logic [DATA_WIDTH-1:0]   rd_word_a;
  logic [DATA_WIDTH-1:0]   rd_word_b;

  // Build the merged write word (enabled bytes from w_data, the rest from the
  // current entry) and pick the word each read port will capture.
  always_comb begin
    write_ok = (state == IDLE) && w_en;
    wr_word  = mem[w_addr];
    for (int i = 0; i < NB; i++) begin
      if (w_be[i]) begin
        wr_word[8*i +: 8] = w_data[8*i +: 8];
      end
    end
    rd_word_a = mem[r_addr_a];
    rd_word_b = mem[r_addr_b];
`ifdef RF_WR_BYPASS_EN
    if (write_ok && (w_addr == r_addr_a)) begin
      rd_word_a = wr_word;
    end
    if (write_ok && (w_addr == r_addr_b)) begin
      rd_word_b = wr_word;
    end
`endif
  end

  // Clear-engine FSM together with the registered read data, busy and w_drop.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= CLEAR;
      clr_ptr  <= '0;
      busy     <= 1'b1;
      w_drop   <= 1'b0;
      r_data_a <= '0;
      r_data_b <= '0;
    end else begin
      case (state)
        CLEAR: begin
          r_data_a <= CLR_VALUE;
          r_data_b <= CLR_VALUE;
          w_drop   <= w_en;
          clr_ptr  <= clr_ptr + 1'b1;
          if (clr_ptr == ADDR_WIDTH'(DEPTH - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        IDLE: begin
          r_data_a <= rd_word_a;
          r_data_b <= rd_word_b;
          w_drop   <= 1'b0;
          if (clr) begin
            state   <= CLEAR;
            clr_ptr <= '0;
            busy    <= 1'b1;
          end
        end
        default: begin
          state   <= CLEAR;
          clr_ptr <= '0;
          busy    <= 1'b1;
        end
      endcase
    end
  end

  // Storage update: the clear engine owns the array while clearing, otherwise
  // accepted writes land; contents are never reset directly.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      if (state == CLEAR) begin
        mem[clr_ptr] <= CLR_VALUE;
      end else if (write_ok) begin
        mem[w_addr] <= wr_word;
      end
    end
  end

endmodule

// File: tb/tb_reg_file_2r1w.sv
// tb_reg_file_2r1w: directed scenarios plus randomized traffic for
// reg_file_2r1w (32-bit words, 8 entries), checked against a behavioural
// model that tracks the array and the remaining clear length.
module tb_reg_file_2r1w;

  localparam int              AW    = 3;
  localparam int              DW    = 32;
  localparam int              NB    = DW / 8;
  localparam int              DEPTH = 1 << AW;
  localparam logic [DW-1:0]   CLRV  = 32'h5EED_F00D;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            w_en;
  logic [AW-1:0]   w_addr;
  logic [DW-1:0]   w_data;
  logic [NB-1:0]   w_be;
  logic [AW-1:0]   r_addr_a;
  logic [AW-1:0]   r_addr_b;
  logic [DW-1:0]   r_data_a;
  logic [DW-1:0]   r_data_b;
  logic            clr;
  logic            busy;
  logic            w_drop;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] model_mem [DEPTH];
  int            clear_left;
  logic [DW-1:0] exp_a;
  logic [DW-1:0] exp_b;
  logic          exp_busy;
  logic          exp_drop;

  reg_file_2r1w #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .CLR_VALUE  (CLRV)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .w_en     (w_en),
    .w_addr   (w_addr),
    .w_data   (w_data),
    .w_be     (w_be),
    .r_addr_a (r_addr_a),
    .r_addr_b (r_addr_b),
    .r_data_a (r_data_a),
    .r_data_b (r_data_b),
    .clr      (clr),
    .busy     (busy),
    .w_drop   (w_drop)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mergeWord(input logic [DW-1:0] old_word,
                                              input logic [DW-1:0] new_word,
                                              input logic [NB-1:0] be);
    logic [DW-1:0] r;
    r = old_word;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) r[8*i +: 8] = new_word[8*i +: 8];
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                             input logic [DW-1:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Reference: clearing is a countdown of DEPTH cycles filling entries in
  // ascending order; reads during it return CLRV and writes are dropped.
  task automatic modelStep();
    logic [DW-1:0] nw;
    if (!reset_n) begin
      exp_a      = '0;
      exp_b      = '0;
      exp_drop   = 1'b0;
      clear_left = DEPTH;
    end else if (clear_left > 0) begin
      model_mem[DEPTH - clear_left] = CLRV;
      clear_left--;
      exp_a    = CLRV;
      exp_b    = CLRV;
      exp_drop = w_en;
    end else begin
      nw    = mergeWord(model_mem[w_addr], w_data, w_be);
      exp_a = model_mem[r_addr_a];
      exp_b = model_mem[r_addr_b];
`ifdef RF_WR_BYPASS_EN
      if (w_en && (w_addr == r_addr_a)) exp_a = nw;
      if (w_en && (w_addr == r_addr_b)) exp_b = nw;
`endif
      if (w_en) model_mem[w_addr] = nw;
      exp_drop = 1'b0;
      if (clr) clear_left = DEPTH;
    end
    exp_busy = (clear_left > 0);
  endtask

  task automatic applyStimulus(input string tag, input logic rst_n,
                               input logic wen, input logic [AW-1:0] wa,
                               input logic [DW-1:0] wd, input logic [NB-1:0] be,
                               input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                               input logic c);
    reset_n  = rst_n;
    w_en     = wen;
    w_addr   = wa;
    w_data   = wd;
    w_be     = be;
    r_addr_a = ra;
    r_addr_b = rb;
    clr      = c;
    modelStep();
    @(posedge clk);
    @(negedge clk);
    checkOutput({tag, "/r_data_a"}, r_data_a, exp_a);
    checkOutput({tag, "/r_data_b"}, r_data_b, exp_b);
    checkOutput({tag, "/busy"}, DW'(busy), DW'(exp_busy));
    checkOutput({tag, "/w_drop"}, DW'(w_drop), DW'(exp_drop));
  endtask

  task automatic idleCycles(input string tag, input int n);
    for (int i = 0; i < n; i++) applyStimulus(tag, 1'b1, 1'b0, '0, '0, '0, '0, '0, 1'b0);
  endtask

  task automatic readAll(input string tag);
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(tag, 1'b1, 1'b0, '0, '0, '0, AW'(i), AW'(DEPTH - 1 - i), 1'b0);
  endtask

  // Directed scenarios followed by randomized traffic.
  initial begin
    logic [DW-1:0] old3;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    clear_left = DEPTH;

    applyStimulus("reset", 1'b0, 1'b0, '0, '0, '0, '0, '0, 1'b0);
    applyStimulus("reset", 1'b0, 1'b1, 3'd2, 32'hFFFF_FFFF, 4'hF, 3'd1, 3'd2, 1'b1);

    idleCycles("t1_clear", DEPTH);
    readAll("t1_read");

    applyStimulus("t2_write", 1'b1, 1'b1, 3'd5, 32'h0000_00A5, 4'b0001, 3'd0, 3'd0, 1'b0);
    applyStimulus("t2_read", 1'b1, 1'b0, '0, '0, '0, 3'd5, 3'd5, 1'b0);
    checkOutput("t2_a5", r_data_a, {CLRV[31:8], 8'hA5});

    applyStimulus("t3_full", 1'b1, 1'b1, 3'd2, 32'h1122_3344, 4'b1111, 3'd0, 3'd1, 1'b0);
    applyStimulus("t3_part", 1'b1, 1'b1, 3'd2, 32'hAABB_CCDD, 4'b0101, 3'd0, 3'd1, 1'b0);
    applyStimulus("t3_read", 1'b1, 1'b0, '0, '0, '0, 3'd2, 3'd2, 1'b0);
    checkOutput("t3_merge", r_data_a, 32'h11BB_33DD);

    old3 = model_mem[3];
    applyStimulus("t5_rw", 1'b1, 1'b1, 3'd3, 32'h0000_005A, 4'hF, 3'd3, 3'd4, 1'b0);
`ifdef RF_WR_BYPASS_EN
    checkOutput("t5_same", r_data_a, 32'h0000_005A);
`else
    checkOutput("t5_same", r_data_a, old3);
`endif
    applyStimulus("t5_next", 1'b1, 1'b0, '0, '0, '0, 3'd3, 3'd3, 1'b0);
    checkOutput("t5_after", r_data_a, 32'h0000_005A);

    applyStimulus("t4_clr", 1'b1, 1'b1, 3'd1, 32'h1234_5678, 4'hF, 3'd1, 3'd1, 1'b1);
    for (int i = 0; i < DEPTH; i++)
      applyStimulus("t4_drop", 1'b1, 1'b1, 3'd1, 32'hDEAD_0000 + i, 4'hF, 3'd1, 3'd6, 1'b0);
    applyStimulus("t4_read", 1'b1, 1'b0, '0, '0, '0, 3'd1, 3'd3, 1'b0);
    checkOutput("t4_addr1", r_data_a, CLRV);

    applyStimulus("t6_write", 1'b1, 1'b1, 3'd6, 32'hCAFE_BABE, 4'hF, 3'd0, 3'd0, 1'b0);
    applyStimulus("t6_clr", 1'b1, 1'b0, '0, '0, '0, '0, '0, 1'b1);
    idleCycles("t6_part", 4);
    applyStimulus("t6_reset", 1'b0, 1'b0, '0, '0, '0, '0, '0, 1'b0);
    idleCycles("t6_restart", DEPTH);
    readAll("t6_read");

    for (int n = 0; n < 600; n++) begin
      applyStimulus("rand",
                    ($urandom_range(0, 149) != 0),
                    1'($urandom_range(0, 1)),
                    AW'($urandom_range(0, DEPTH - 1)),
                    DW'($urandom),
                    NB'($urandom_range(0, (1 << NB) - 1)),
                    AW'($urandom_range(0, DEPTH - 1)),
                    AW'($urandom_range(0, DEPTH - 1)),
                    ($urandom_range(0, 39) == 0));
    end
    idleCycles("drain", DEPTH + 1);
    readAll("final_read");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
